// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALUOp codes
// and datapath mux-select values.
package mc_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. Memory handshake: a request (fetch in S_FETCH,
// adr_src=1 in S_MEMREAD/S_MEMWRITE) is held every cycle until mem_ready=1, which completes it.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       funct3_0;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct3_0, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal
  );

  modport slave (
    output opcode, funct3_0, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal
  );
endinterface

// File: rtl/imm_src_decoder.sv
// Immediate-format select, decoded purely from the opcode in every state.
module imm_src_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multicycle RV32I-subset core: Moore-decoded datapath
// controls, qualified by mem_ready in memory states and by zero/funct3_0 in S_BRANCH.
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus,
  output state_t                      dbg_state
);
  state_t     state, next_state;
  logic       pc_update, branch;
  logic       adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  imm_src_decoder u_imm (.opcode(bus.opcode), .imm_src(bus.imm_src));

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
        if (bus.mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut for a possible branch
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_JAL:            next_state = S_JAL;
          OP_BRANCH:         next_state = S_BRANCH;
          default:           next_state = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_FUNCT;
        next_state = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_ERROR: illegal = 1'b1;
      default: next_state = S_ERROR;
    endcase
    // A reset cycle must not commit or retire anything, even mid-instruction
    if (reset) begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign bus.pc_write   = pc_update | (branch & (bus.zero ^ bus.funct3_0));
  assign bus.adr_src    = adr_src;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.instr_done = instr_done;
  assign bus.illegal    = illegal;
  assign dbg_state      = state;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: cycle-by-cycle vector table plus hand-written
// sequences for error absorption and mid-instruction reset.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, aop, imm;
    logic       done, ill;
  } out_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       f3, z, mr;
    state_t     st;
    out_t       o;
  } vec_t;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;
  int     checks = 0;
  int     failures = 0;
  vec_t   tbl[$];

  multicycle_control_if ifc ();

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifc.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic vec_t v(input logic rst, input logic [6:0] op, input logic f3, z, mr,
                             input state_t st, input logic pcw, adr, mw, irw, rw,
                             input logic [1:0] rs, sa, sb, aop, imm, input logic done, ill);
    vec_t r;
    r.rst = rst; r.op = op; r.f3 = f3; r.z = z; r.mr = mr; r.st = st;
    r.o.pcw = pcw; r.o.adr = adr; r.o.mw = mw; r.o.irw = irw; r.o.rw = rw;
    r.o.rs = rs; r.o.sa = sa; r.o.sb = sb; r.o.aop = aop; r.o.imm = imm;
    r.o.done = done; r.o.ill = ill;
    return r;
  endfunction

  function automatic out_t sample();
    out_t s;
    s.pcw = ifc.pc_write; s.adr = ifc.adr_src; s.mw = ifc.mem_write;
    s.irw = ifc.ir_write; s.rw = ifc.reg_write; s.rs = ifc.result_src;
    s.sa = ifc.alu_src_a; s.sb = ifc.alu_src_b; s.aop = ifc.alu_op;
    s.imm = ifc.imm_src; s.done = ifc.instr_done; s.ill = ifc.illegal;
    return s;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: one cycle, inputs changed on negedge, outputs settled 1 time unit later
  task automatic cyc(input logic rst, input logic [6:0] op, input logic f3, z, mr);
    @(negedge clk);
    reset = rst; ifc.opcode = op; ifc.funct3_0 = f3; ifc.zero = z; ifc.mem_ready = mr;
    #1;
  endtask

  function automatic logic any_enable();
    return ifc.pc_write | ifc.mem_write | ifc.ir_write | ifc.reg_write | ifc.instr_done;
  endfunction

  initial begin
    // rst op f3 z mr state | pcw adr mw irw rw | rs sa sb aop imm | done ill
    // add
    tbl.push_back(v(0,OP_R,0,0,1,S_FETCH,   1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_R,0,0,0,S_DECODE,  0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_R,0,0,0,S_EXEC_R,  0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00, 0,0));
    tbl.push_back(v(0,OP_R,0,0,1,S_ALUWB,   0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 1,0));
    // addi, one fetch wait
    tbl.push_back(v(0,OP_I,0,0,0,S_FETCH,   0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_I,0,0,1,S_FETCH,   1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_I,0,0,1,S_DECODE,  0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_I,0,0,1,S_EXEC_I,  0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10,2'b00, 0,0));
    tbl.push_back(v(0,OP_I,0,0,0,S_ALUWB,   0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 1,0));
    // lw, mem_ready low 2 cycles in MEMREAD
    tbl.push_back(v(0,OP_LOAD,0,0,1,S_FETCH,  1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_LOAD,0,0,1,S_DECODE, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_LOAD,0,0,1,S_MEMADR, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_LOAD,0,0,0,S_MEMREAD,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_LOAD,0,0,0,S_MEMREAD,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_LOAD,0,0,1,S_MEMREAD,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,OP_LOAD,0,0,1,S_MEMWB,  0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b00, 1,0));
    // sw, mem_ready low 1 cycle
    tbl.push_back(v(0,OP_STORE,0,0,1,S_FETCH,   1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b01, 0,0));
    tbl.push_back(v(0,OP_STORE,0,0,1,S_DECODE,  0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b01, 0,0));
    tbl.push_back(v(0,OP_STORE,0,0,0,S_MEMADR,  0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01, 0,0));
    tbl.push_back(v(0,OP_STORE,0,0,0,S_MEMWRITE,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 0,0));
    tbl.push_back(v(0,OP_STORE,0,0,1,S_MEMWRITE,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 1,0));
    // beq taken
    tbl.push_back(v(0,OP_BRANCH,0,1,1,S_FETCH, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
    tbl.push_back(v(0,OP_BRANCH,0,1,1,S_DECODE,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0));
    tbl.push_back(v(0,OP_BRANCH,0,1,1,S_BRANCH,1,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 1,0));
    // bne with zero=1: not taken
    tbl.push_back(v(0,OP_BRANCH,1,1,1,S_FETCH, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
    tbl.push_back(v(0,OP_BRANCH,1,1,1,S_DECODE,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0));
    tbl.push_back(v(0,OP_BRANCH,1,1,1,S_BRANCH,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 1,0));
    // bne with zero=0: taken
    tbl.push_back(v(0,OP_BRANCH,1,0,1,S_FETCH, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
    tbl.push_back(v(0,OP_BRANCH,1,0,1,S_DECODE,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0));
    tbl.push_back(v(0,OP_BRANCH,1,0,0,S_BRANCH,1,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 1,0));
    // jal
    tbl.push_back(v(0,OP_JAL,0,0,1,S_FETCH, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b11, 0,0));
    tbl.push_back(v(0,OP_JAL,0,0,1,S_DECODE,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b11, 0,0));
    tbl.push_back(v(0,OP_JAL,0,0,1,S_JAL,   1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00,2'b11, 0,0));
    tbl.push_back(v(0,OP_JAL,0,0,1,S_ALUWB, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b11, 1,0));
    // illegal opcode, then one reset edge
    tbl.push_back(v(0,7'd0,0,0,1,S_FETCH, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,7'd0,0,0,1,S_DECODE,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
    tbl.push_back(v(0,7'd0,0,1,1,S_ERROR, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1));
    tbl.push_back(v(1,7'd0,0,0,1,S_ERROR, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1));
    tbl.push_back(v(0,7'd0,0,0,0,S_FETCH, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));

    // reset state: FETCH with every enable held low despite mem_ready=1
    cyc(1, OP_R, 0, 0, 1);
    cyc(1, OP_R, 0, 0, 1);
    check("reset_state", 32'(dbg_state), 32'(S_FETCH));
    check("reset_enables", 32'(any_enable()), 32'd0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].mr);
      check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(tbl[i].st));
      check($sformatf("vec%0d_outs", i), 32'(sample()), 32'(tbl[i].o));
    end

    // illegal opcode absorbs for 10 cycles regardless of mem_ready
    cyc(0, 7'd0, 0, 0, 1);
    cyc(0, 7'd0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 7'd0, k[0], k[1], 1);
      check($sformatf("err%0d_state", k), 32'(dbg_state), 32'(S_ERROR));
      check($sformatf("err%0d_illegal", k), 32'(ifc.illegal), 32'd1);
      check($sformatf("err%0d_enables", k), 32'(any_enable()), 32'd0);
    end
    cyc(1, 7'd0, 0, 0, 1);
    cyc(0, OP_STORE, 0, 0, 1);
    check("err_reset_state", 32'(dbg_state), 32'(S_FETCH));

    // reset raised during a pending store
    cyc(0, OP_STORE, 0, 0, 1);
    cyc(0, OP_STORE, 0, 0, 1);
    cyc(0, OP_STORE, 0, 0, 0);
    check("sw_pending_state", 32'(dbg_state), 32'(S_MEMWRITE));
    check("sw_pending_mw", 32'(ifc.mem_write), 32'd1);
    cyc(1, OP_STORE, 0, 0, 1);
    check("sw_rst_mw", 32'(ifc.mem_write), 32'd0);
    check("sw_rst_done", 32'(ifc.instr_done), 32'd0);
    cyc(0, OP_STORE, 0, 0, 0);
    check("sw_after_state", 32'(dbg_state), 32'(S_FETCH));
    check("sw_after_mw", 32'(ifc.mem_write), 32'd0);

    // reset landing on an ALU writeback suppresses the write and retire
    cyc(0, OP_R, 0, 0, 1);
    cyc(0, OP_R, 0, 0, 1);
    cyc(0, OP_R, 0, 0, 1);
    cyc(1, OP_R, 0, 0, 1);
    check("aluwb_rst_state", 32'(dbg_state), 32'(S_ALUWB));
    check("aluwb_rst_rw", 32'(ifc.reg_write), 32'd0);
    check("aluwb_rst_done", 32'(ifc.instr_done), 32'd0);
    cyc(0, OP_R, 0, 0, 0);
    check("aluwb_after_state", 32'(dbg_state), 32'(S_FETCH));

    // reset wins over mem_ready completing a load
    cyc(0, OP_LOAD, 0, 0, 1);
    cyc(0, OP_LOAD, 0, 0, 1);
    cyc(0, OP_LOAD, 0, 0, 1);
    cyc(1, OP_LOAD, 0, 0, 1);
    check("lw_rst_state", 32'(dbg_state), 32'(S_MEMREAD));
    cyc(0, OP_LOAD, 0, 0, 0);
    check("lw_after_state", 32'(dbg_state), 32'(S_FETCH));
    check("lw_after_rw", 32'(ifc.reg_write), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main sequencing FSM for the multicycle RV32I-subset core.
- Each cycle it drives the datapath mux selects, the register-file, memory and IR write enables, and the 2-bit ALUOp consumed by the ALU decode stage (00 add, 01 subtract, 10 funct-decoded).
- Supports lw, sw, R-type ALU, I-type ALU, jal, beq/bne.
- Handles a single shared instruction/data memory with a ready handshake.

Parameters:
- STATE_W, 4, width of the state register (must hold 12 states).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; state returns to S_FETCH on the next edge
- opcode  in  7  instr[6:0] from the instruction register; stable from S_DECODE onward
- funct3_0  in  1  instr[12]; 0 = beq, 1 = bne
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_write  out  1  PC load enable; equals pc_update OR (branch_taken in S_BRANCH)
- adr_src  out  1  memory address select; 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_write  out  1  register-file write
- result_src  out  2  result select; 00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  out  2  ALU A select; 00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  ALU B select; 00 rs2, 01 imm, 10 constant 4
- alu_op  out  2  to ALU decode; 00 add, 01 sub, 10 funct
- imm_src  out  2  immediate format; 00 I, 01 S, 10 B, 11 J
- instr_done  out  1  1-cycle pulse on the edge an instruction retires, i.e. the last cycle before returning to S_FETCH
- illegal  out  1  high while in S_ERROR

Behaviour:
- Outputs are Moore decoded from the state register, except where qualified by mem_ready, zero or funct3_0.
- Unlisted outputs are 0 and selects are 00.
- While reset=1, all enables are forced to 0.
- First post-reset cycle: state is S_FETCH.
- S_FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in S_FETCH until mem_ready=1, then goes to S_DECODE.
- S_DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 → S_MEMADR
    - 0110011 → S_EXEC_R
    - 0010011 → S_EXEC_I
    - 1101111 → S_JAL
    - 1100011 → S_BRANCH
    - any other value → S_ERROR
- S_MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is S_MEMREAD for lw, S_MEMWRITE for sw.
- S_MEMREAD: adr_src=1; waits for mem_ready, then S_MEMWB.
- S_MEMWB: result_src=01, reg_write=1, instr_done=1; next S_FETCH.
- S_MEMWRITE:
  - adr_src=1; mem_write held at 1 until the cycle mem_ready=1 inclusive.
  - That cycle: instr_done=1, next S_FETCH.
- S_EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; next S_ALUWB.
- S_EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10; next S_ALUWB.
- S_JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
  - Next S_ALUWB (writes PC+4 into rd).
- S_ALUWB: result_src=00, reg_write=1, instr_done=1; next S_FETCH.
- S_BRANCH:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - branch_taken = zero XOR funct3_0; pc_write=branch_taken.
  - instr_done=1; next S_FETCH.
- S_ERROR: illegal=1, all enables 0; absorbing until reset.
- imm_src is combinational from opcode in every state:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - anything else → 00
- Latency in cycles, with mem_ready=1 on first request:
  - R-type, I-type, jal: 4
  - beq/bne: 3
  - sw: 4
  - lw: 5
  - Each mem_ready=0 cycle adds one cycle.
- Reset asserted mid-instruction (including during a pending mem_write or wait): next state S_FETCH, no reg_write or pc_write that cycle, no partial retire pulse.
- mem_ready is ignored in states that do not access memory.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings S_FETCH..S_ERROR
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH
  - ALUOp constants 00/01/10
  - mux-select constants for result_src, alu_src_a, alu_src_b, imm_src
- One sub-module: imm_src_decoder (opcode → imm_src, purely combinational).

Test Plan:
- Reset, then add (opcode 0110011) with mem_ready=1:
  - states FETCH, DECODE, EXEC_R, ALUWB
  - alu_op=10 in EXEC_R; reg_write=1 in cycle 4 only; instr_done in cycle 4
- lw with mem_ready low 2 cycles in MEMREAD:
  - MEMREAD held for 3 cycles with adr_src=1
  - MEMWB result_src=01, reg_write=1; total 7 cycles
- sw with mem_ready=0 for 1 cycle: mem_write=1 for 2 consecutive cycles, then FETCH; reg_write never 1.
- beq with zero=1 → pc_write=1, alu_op=01 in the BRANCH cycle.
- bne (funct3_0=1) with zero=1 → pc_write=0; instr_done=1 in both cases.
- jal: pc_write=1 in S_JAL, then reg_write=1 with result_src=00; imm_src=11 throughout.
- Illegal opcode 0000000 → S_ERROR, illegal=1, enables stay 0 for 10 cycles; reset for one edge returns to FETCH.
- Reset raised mid-S_MEMWRITE → mem_write=0 on the next cycle.
